// File: rtl/spi_master.sv
// Single-byte SPI master with runtime CPOL/CPHA and valid/ready host handshake.
// Define SPI_LSB_FIRST_EN to shift LSB first (default build shifts MSB first).
module spi_master #(
  parameter int value_divide = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       CS_input,
  input  logic       valid,
  input  logic [7:0] data_send,
  output logic       ready,
  output logic [7:0] data_receive,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       CS_output
);

  localparam int H  = value_divide / 2;
  localparam int CW = 8;
  localparam logic [CW-1:0] HM1 = CW'(H - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    half_q;
  logic          cpol_q, cpha_q, sclk_q, mosi_q, ready_q;
  logic [7:0]    rx_data_q;
  logic [6:0]    tx_q;
  logic [7:0]    rx_q;

  logic       accept, half_end, edge_en, lead, shift_en, sample_en;
  logic       first_bit, next_bit;
  logic [6:0] tx_load, tx_shifted;
  logic [7:0] rx_shifted;

  // tx_q holds only the bits not yet driven; mosi_q carries the current bit
`ifdef SPI_LSB_FIRST_EN
  assign first_bit  = data_send[0];
  assign tx_load    = data_send[7:1];
  assign next_bit   = tx_q[0];
  assign tx_shifted = {1'b0, tx_q[6:1]};
  assign rx_shifted = {spi_miso, rx_q[7:1]};
`else
  assign first_bit  = data_send[7];
  assign tx_load    = data_send[6:0];
  assign next_bit   = tx_q[6];
  assign tx_shifted = {tx_q[5:0], 1'b0};
  assign rx_shifted = {rx_q[6:0], spi_miso};
`endif

  assign accept   = (state_q == IDLE) && ready_q && valid;
  assign half_end = (cnt_q == HM1);
  assign edge_en  = (state_q == SHIFT) && half_end;
  assign lead     = ~half_q[0];

  // CPHA=1 already presents bit 0 during SETUP, so the first leading edge must not shift
  assign shift_en  = edge_en && (cpha_q ? (lead && (half_q != 4'd0)) : ~lead);
  assign sample_en = edge_en && (cpha_q ? ~lead : lead);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      rx_data_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SETUP;
            cnt_q   <= '0;
            cpol_q  <= CPOL;
            cpha_q  <= CPHA;
            sclk_q  <= CPOL;
            mosi_q  <= first_bit;
            ready_q <= 1'b0;
          end
        end
        SETUP: begin
          if (half_end) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            half_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (half_end) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            if (shift_en) mosi_q <= next_bit;
            if (half_q == 4'd15) state_q <= HOLD;
            else                 half_q  <= half_q + 4'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (half_end) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            mosi_q    <= 1'b0;
            rx_data_q <= rx_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)        tx_q <= tx_load;
    else if (shift_en) tx_q <= tx_shifted;
    if (sample_en)     rx_q <= rx_shifted;
  end

  // While idle the pins track the host's live CPOL and chip-select levels
  assign spi_clk      = (state_q == IDLE) ? CPOL : sclk_q;
  assign CS_output    = (state_q == IDLE) ? CS_input : 1'b0;
  assign ready        = ready_q;
  assign spi_mosi     = mosi_q;
  assign data_receive = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed loopback bench for spi_master (MISO tied to MOSI, default divide of 4).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       CPOL, CPHA, CS_input, valid;
  logic [7:0] data_send;
  logic       ready;
  logic [7:0] data_receive;
  logic       spi_clk, spi_mosi, spi_miso, CS_output;

  int checks = 0;
  int errors = 0;

  int         lat, rises;
  logic [7:0] mseq, dr35;
  logic       cs_ok;

  always #5 clk = ~clk;

  assign spi_miso = spi_mosi;

  spi_master #(.value_divide(4)) dut (
    .clk(clk), .rst_n(rst_n), .CPOL(CPOL), .CPHA(CPHA), .CS_input(CS_input),
    .valid(valid), .data_send(data_send), .ready(ready), .data_receive(data_receive),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .CS_output(CS_output)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after ready rises (or budget expiry).
  task automatic xfer(input logic [7:0] d, input logic inj, output int lat_o,
                      output int rises_o, output logic [7:0] mseq_o,
                      output logic [7:0] dr35_o, output logic cs_ok_o);
    logic prev;
    int n;
    valid = 1'b1;
    data_send = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data_send = 8'h00;
    n = 0; rises_o = 0; mseq_o = 8'h00; dr35_o = 8'h00; cs_ok_o = 1'b1; lat_o = -1;
    prev = spi_clk;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (spi_clk && !prev) rises_o++;
      prev = spi_clk;
      if (n >= 4 && n <= 32 && (n % 4) == 0) mseq_o = {mseq_o[6:0], spi_mosi};
      if (n == 35) dr35_o = data_receive;
      if (n < 36 && CS_output !== 1'b0) cs_ok_o = 1'b0;
      if (inj && n == 10) begin
        valid = 1'b1;
        data_send = 8'h12;
      end else if (inj && n == 11) begin
        valid = 1'b0;
        data_send = 8'h00;
      end
      if (ready) begin
        lat_o = n;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; CPOL = 1'b1; CPHA = 1'b0; CS_input = 1'b1; valid = 1'b0; data_send = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_data", data_receive, 8'h00);
    check("rst_mosi", spi_mosi, 0);
    check("rst_sclk", spi_clk, 1);
    check("rst_cs", CS_output, 1);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(8'hAF, 1'b0, lat, rises, mseq, dr35, cs_ok);
    check("af_lat", lat, 36);
    check("af_data", data_receive, 8'hAF);
    check("af_rises", rises, 8);
    check("af_cs_low", cs_ok, 1);
    check("af_sclk_idle", spi_clk, 1);
    check("af_cs_idle", CS_output, 1);

    xfer(8'h55, 1'b0, lat, rises, mseq, dr35, cs_ok);
    check("55_lat", lat, 36);
    check("55_data", data_receive, 8'h55);
    check("55_mosi_seq", mseq, 8'b0101_0101);
    check("55_hold_old", dr35, 8'hAF);

    for (int m = 0; m < 4; m++) begin
      CPOL = m[1];
      CPHA = m[0];
      @(negedge clk);
      check("mode_idle_sclk", spi_clk, m[1]);
      xfer(8'hA5, 1'b0, lat, rises, mseq, dr35, cs_ok);
      check("mode_lat", lat, 36);
      check("mode_data", data_receive, 8'hA5);
      check("mode_rises", rises, 8);
      check("mode_end_sclk", spi_clk, m[1]);
    end

    CPOL = 1'b0; CPHA = 1'b1;
    @(negedge clk);
    xfer(8'h3C, 1'b1, lat, rises, mseq, dr35, cs_ok);
    check("busy_lat", lat, 36);
    check("busy_data", data_receive, 8'h3C);
    repeat (3) @(negedge clk);
    check("busy_ignored_ready", ready, 1);
    check("busy_ignored_data", data_receive, 8'h3C);

    CPOL = 1'b1; CPHA = 1'b0;
    valid = 1'b1;
    data_send = 8'hC3;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("mid_busy", ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_data", data_receive, 8'h00);
    check("abort_sclk", spi_clk, 1);
    check("abort_cs", CS_output, 1);
    check("abort_mosi", spi_mosi, 0);
    @(negedge clk);
    rst_n = 1'b1;

    CS_input = 1'b0;
    @(negedge clk);
    check("cs0_idle", CS_output, 0);
    xfer(8'h81, 1'b0, lat, rises, mseq, dr35, cs_ok);
    check("cs0_data", data_receive, 8'h81);
    check("cs0_between", CS_output, 0);
    CS_input = 1'b1;
    #1;
    check("cs1_idle", CS_output, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
